// File: rtl/nios_led3_timer_sched_pkg.sv
// rtl/nios_led3_timer_sched_pkg.sv - shared types and interval-timer register map
package nios_led3_timer_sched_pkg;

    typedef enum logic [2:0] {
        S_CFG_PL,
        S_CFG_PH,
        S_CFG_CTL,
        S_RUN,
        S_ACK,
        S_TICK
    } state_e;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTL_RUN_WORD =
        16'((1 << CTL_ITO) | (1 << CTL_CONT) | (1 << CTL_START));

endpackage

// File: rtl/nios_led3_timer_sched_chan.sv
// rtl/nios_led3_timer_sched_chan.sv - one soft-timer channel: countdown, active flag, done pulse
module nios_led3_timer_sched_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             cancel_i,
    output logic             active_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (cancel_i) begin
            active_d = 1'b0;
        end else if (load_i) begin
            // A zero delay expires immediately without ever becoming active.
            cnt_d    = delay_i;
            active_d = (delay_i != '0);
            done_d   = (delay_i == '0);
        end else if (tick_i && active_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign active_o = active_q;
    assign done_o   = done_q;

endmodule

// File: rtl/nios_led3_timer_sched.sv
// rtl/nios_led3_timer_sched.sv - programs the interval timer, services its irq and fans ticks to NUM_CH soft timers
module nios_led3_timer_sched #(
    parameter int          NUM_CH = 4,
    parameter int          CNT_W  = 16,
    parameter logic [31:0] PERIOD = 32'd49999
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*CNT_W-1:0] req_delay,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH-1:0]       cancel,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       done,
    output logic                    cfg_done,
    output logic [2:0]              tm_address,
    output logic                    tm_chipselect,
    output logic                    tm_write_n,
    output logic [15:0]             tm_writedata,
    input  logic                    tm_irq
);
    import nios_led3_timer_sched_pkg::*;

    state_e      state_q, state_d;
    logic        bus_cs;
    logic [2:0]  bus_addr;
    logic [15:0] bus_data;
    logic        running;
    logic        tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_CFG_PL;
        end else begin
            state_q <= state_d;
        end
    end

    // Period writes stop the timer, so the start write must come last.
    always_comb begin
        state_d  = state_q;
        bus_cs   = 1'b0;
        bus_addr = TMR_STATUS;
        bus_data = '0;
        running  = 1'b0;
        tick     = 1'b0;
        case (state_q)
            S_CFG_PL: begin
                bus_cs   = 1'b1;
                bus_addr = TMR_PERIODL;
                bus_data = PERIOD[15:0];
                state_d  = S_CFG_PH;
            end
            S_CFG_PH: begin
                bus_cs   = 1'b1;
                bus_addr = TMR_PERIODH;
                bus_data = PERIOD[31:16];
                state_d  = S_CFG_CTL;
            end
            S_CFG_CTL: begin
                bus_cs   = 1'b1;
                bus_addr = TMR_CONTROL;
                bus_data = CTL_RUN_WORD;
                state_d  = S_RUN;
            end
            S_RUN: begin
                running = 1'b1;
                if (tm_irq) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                bus_cs   = 1'b1;
                bus_addr = TMR_STATUS;
                running  = 1'b1;
                state_d  = S_TICK;
            end
            S_TICK: begin
                running = 1'b1;
                tick    = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_CFG_PL;
        endcase
    end

    // Held idle while reset is asserted so the bus and cfg_done show their reset values.
    assign tm_chipselect = bus_cs & reset_n;
    assign tm_write_n    = ~tm_chipselect;
    assign tm_address    = reset_n ? bus_addr : TMR_STATUS;
    assign tm_writedata  = reset_n ? bus_data : 16'h0000;
    assign cfg_done      = running & reset_n;
    assign req_ready     = {NUM_CH{cfg_done}} & ~cancel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nios_led3_timer_sched_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick_i   (tick),
            .load_i   (req_valid[i] & req_ready[i]),
            .delay_i  (req_delay[i*CNT_W +: CNT_W]),
            .cancel_i (cancel[i]),
            .active_o (active[i]),
            .done_o   (done[i])
        );
    end

endmodule

// File: tb/tb_nios_led3_timer_sched.sv
// tb/tb_nios_led3_timer_sched.sv - bench with interval-timer model and tick-indexed channel reference
module tb_nios_led3_timer_sched;
    localparam int          NUM_CH = 4;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] PERIOD = 32'd9;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_CH-1:0]       req_valid = '0;
    logic [NUM_CH*CNT_W-1:0] req_delay = '0;
    logic [NUM_CH-1:0]       cancel = '0;
    logic [NUM_CH-1:0]       req_ready, active, done;
    logic                    cfg_done, tm_chipselect, tm_write_n, tm_irq;
    logic [2:0]              tm_address;
    logic [15:0]             tm_writedata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios_led3_timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_delay(req_delay),
        .req_ready(req_ready), .cancel(cancel), .active(active), .done(done),
        .cfg_done(cfg_done), .tm_address(tm_address), .tm_chipselect(tm_chipselect),
        .tm_write_n(tm_write_n), .tm_writedata(tm_writedata), .tm_irq(tm_irq)
    );

    // Interval timer: counts period..0, flags timeout, reloads when continuous.
    logic [31:0] t_period = '0, t_cnt = '0;
    logic        t_run = 1'b0, t_cont = 1'b0, t_ito = 1'b0, t_to = 1'b0;
    int          n_status = 0;
    assign tm_irq = t_to & t_ito;

    always @(posedge clk) begin
        if (t_run) begin
            if (t_cnt == 0) begin
                t_to  <= 1'b1;
                t_cnt <= t_period;
                if (!t_cont) t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 1;
            end
        end
        if (tm_chipselect && !tm_write_n) begin
            case (tm_address)
                3'd0: begin t_to <= 1'b0; n_status <= n_status + 1; end
                3'd1: begin
                    t_ito  <= tm_writedata[0];
                    t_cont <= tm_writedata[1];
                    if (tm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                    if (tm_writedata[3]) t_run <= 1'b0;
                end
                3'd2: begin t_period[15:0]  <= tm_writedata; t_run <= 1'b0; end
                3'd3: begin t_period[31:16] <= tm_writedata; t_run <= 1'b0; end
                default: ;
            endcase
        end
    end

    // Reference: ticks are numbered; an arm of N expires right after tick number (ticks so far + N).
    int                cyc = 0, tick_cnt = 0, onsets = 0, last_onset = 0, onset_gap = 0;
    logic [3:0]        ih = '0;
    bit                cfg_exp = 1'b0;
    bit                m_armed[NUM_CH] = '{default: 1'b0};
    int                m_target[NUM_CH] = '{default: 0};
    logic [NUM_CH-1:0] exp_done = '0, exp_active = '0;

    task automatic step();
        logic [NUM_CH-1:0] nd, na;
        bit tk;
        tk = ih[2] & ~ih[3];
        nd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int dl;
            dl = int'(req_delay[i*CNT_W +: CNT_W]);
            if (cancel[i]) begin
                m_armed[i] = 1'b0;
            end else if (req_valid[i] && cfg_exp) begin
                if (dl == 0) begin
                    m_armed[i] = 1'b0;
                    nd[i] = 1'b1;
                end else begin
                    m_armed[i]  = 1'b1;
                    m_target[i] = tick_cnt + (tk ? 1 : 0) + dl;
                end
            end else if (tk && m_armed[i] && m_target[i] == tick_cnt + 1) begin
                m_armed[i] = 1'b0;
                nd[i] = 1'b1;
            end
            na[i] = m_armed[i];
        end
        if (tk) tick_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        ih = {ih[2:0], tm_irq};
        if (ih[0] & ~ih[1]) begin
            onset_gap  = cyc - last_onset;
            last_onset = cyc;
            onsets++;
        end
        exp_done   = nd;
        exp_active = na;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (tm_chipselect !== 1'b0 || tm_write_n !== 1'b1) begin
            errors++; $display("FAIL reset_bus: cs=%b wn=%b want cs=0 wn=1", tm_chipselect, tm_write_n);
        end
        checks++;
        if (tm_address !== 3'd0 || tm_writedata !== 16'h0) begin
            errors++; $display("FAIL reset_addr_data: got %0d/%h want 0/0000", tm_address, tm_writedata);
        end
        checks++;
        if (done !== '0 || active !== '0 || cfg_done !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL reset_outputs: done=%b active=%b cfg=%b rdy=%b want all 0", done, active, cfg_done, req_ready);
        end
    endtask

    task automatic test_config();
        logic [2:0]  ea[3];
        logic [15:0] ed[3];
        int          o0, g;
        ea = '{3'd2, 3'd3, 3'd1};
        ed = '{PERIOD[15:0], PERIOD[31:16], 16'h0007};
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tm_chipselect !== 1'b1 || tm_write_n !== 1'b0 || tm_address !== ea[k] ||
                tm_writedata !== ed[k] || cfg_done !== 1'b0) begin
                errors++; $display("FAIL cfg_write%0d: cs=%b wn=%b a=%0d d=%h cfg=%b want cs=1 wn=0 a=%0d d=%h cfg=0",
                                   k, tm_chipselect, tm_write_n, tm_address, tm_writedata, cfg_done, ea[k], ed[k]);
            end
            step();
        end
        cfg_exp = 1'b1;
        checks++;
        if (cfg_done !== 1'b1 || tm_chipselect !== 1'b0 || tm_write_n !== 1'b1) begin
            errors++; $display("FAIL cfg_done_rise: cfg=%b cs=%b wn=%b want 1/0/1", cfg_done, tm_chipselect, tm_write_n);
        end
        o0 = onsets;
        g  = 0;
        while (onsets < o0 + 2 && g < 40) begin step(); g++; end
        checks++;
        if (onsets < o0 + 2) begin
            errors++; $display("FAIL irq_start: saw %0d irqs want 2 within 40 cycles", onsets - o0);
        end else if (onset_gap != 10) begin
            errors++; $display("FAIL irq_period: gap %0d want 10", onset_gap);
        end
    endtask

    task automatic test_irq_service();
        int t0, s0, g;
        while ((ih[1] & ~ih[2]) | (ih[2] & ~ih[3])) step();
        t0 = tick_cnt;
        s0 = n_status;
        g  = 0;
        while (tick_cnt < t0 + 100 && g < 1500) begin
            step();
            g++;
            if (ih[0] & ~ih[1]) begin
                checks++;
                if (onset_gap != 10) begin
                    errors++; $display("FAIL irq_gap: gap %0d want 10", onset_gap);
                end
            end
        end
        checks++;
        if (n_status - s0 != tick_cnt - t0 || tick_cnt - t0 != 100) begin
            errors++; $display("FAIL status_writes: writes=%0d ticks=%0d want 100/100", n_status - s0, tick_cnt - t0);
        end
    endtask

    task automatic test_same_expiry();
        int g;
        req_valid = 4'b0101;
        req_delay[0*CNT_W +: CNT_W] = 16'd3;
        req_delay[2*CNT_W +: CNT_W] = 16'd3;
        step();
        req_valid = '0;
        g = 0;
        while (!exp_done[0] && g < 60) begin
            checks++;
            if (done !== exp_done || active !== exp_active) begin
                errors++; $display("FAIL same_wait: done=%b active=%b want %b/%b", done, active, exp_done, exp_active);
            end
            step();
            g++;
        end
        checks++;
        if (done[0] !== 1'b1 || done[2] !== 1'b1 || active[0] !== 1'b0 || active[2] !== 1'b0) begin
            errors++; $display("FAIL same_expiry: done=%b active=%b want done[0,2]=1 active[0,2]=0", done, active);
        end
        step();
        checks++;
        if (done !== '0) begin
            errors++; $display("FAIL same_pulse_width: done=%b want 0000", done);
        end
    endtask

    task automatic test_cancel();
        int t_arm, g;
        req_valid = 4'b0010;
        req_delay[1*CNT_W +: CNT_W] = 16'd5;
        step();
        req_valid = '0;
        t_arm = tick_cnt;
        g = 0;
        while (tick_cnt < t_arm + 2 && g < 60) begin
            checks++;
            if (done !== exp_done || active !== exp_active) begin
                errors++; $display("FAIL cancel_wait: done=%b active=%b want %b/%b", done, active, exp_done, exp_active);
            end
            step();
            g++;
        end
        cancel = 4'b0010;
        #1;
        checks++;
        if (req_ready[1] !== 1'b0 || active[1] !== 1'b1) begin
            errors++; $display("FAIL cancel_ready: rdy1=%b active1=%b want 0/1", req_ready[1], active[1]);
        end
        step();
        cancel = '0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (done[1] !== 1'b0 || active[1] !== 1'b0) begin
                errors++; $display("FAIL cancel_quiet: done1=%b active1=%b want 0/0", done[1], active[1]);
            end
            step();
        end
        req_valid = 4'b0010;
        req_delay[1*CNT_W +: CNT_W] = 16'd1;
        step();
        req_valid = '0;
        g = 0;
        while (!exp_done[1] && g < 30) begin
            checks++;
            if (done !== exp_done || active !== exp_active) begin
                errors++; $display("FAIL rearm_wait: done=%b active=%b want %b/%b", done, active, exp_done, exp_active);
            end
            step();
            g++;
        end
        checks++;
        if (done[1] !== 1'b1 || active[1] !== 1'b0) begin
            errors++; $display("FAIL rearm_done: done1=%b active1=%b want 1/0", done[1], active[1]);
        end
    endtask

    task automatic test_zero_and_tick_arm();
        int g;
        req_valid = 4'b1000;
        req_delay[3*CNT_W +: CNT_W] = 16'd0;
        step();
        req_valid = '0;
        checks++;
        if (done[3] !== 1'b1 || active[3] !== 1'b0) begin
            errors++; $display("FAIL zero_delay: done3=%b active3=%b want 1/0", done[3], active[3]);
        end
        step();
        checks++;
        if (done[3] !== 1'b0) begin
            errors++; $display("FAIL zero_pulse: done3=%b want 0", done[3]);
        end
        g = 0;
        while (!(ih[2] & ~ih[3]) && g < 30) begin step(); g++; end
        checks++;
        if (g >= 30) begin
            errors++; $display("FAIL tick_wait: no tick cycle within %0d cycles", g);
        end
        req_valid = 4'b1000;
        req_delay[3*CNT_W +: CNT_W] = 16'd2;
        step();
        req_valid = '0;
        g = 0;
        while (!exp_done[3] && g < 40) begin
            checks++;
            if (done !== exp_done || active !== exp_active) begin
                errors++; $display("FAIL tick_arm_wait: done=%b active=%b want %b/%b", done, active, exp_done, exp_active);
            end
            step();
            g++;
        end
        checks++;
        if (done[3] !== 1'b1) begin
            errors++; $display("FAIL tick_arm_done: done3=%b want 1", done[3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                cancel[i]    = (r < 3);
                req_valid[i] = (r >= 3 && r < 12);
                req_delay[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 3));
            end
            #1;
            checks++;
            if (req_ready !== ~cancel) begin
                errors++; $display("FAIL rand_ready: rdy=%b want %b", req_ready, ~cancel);
            end
            step();
            checks++;
            if (done !== exp_done || active !== exp_active) begin
                errors++; $display("FAIL rand_chan: cycle %0d done=%b active=%b want %b/%b", cyc, done, active, exp_done, exp_active);
            end
        end
        cancel    = '0;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [2:0]  ea[3];
        logic [15:0] ed[3];
        ea = '{3'd2, 3'd3, 3'd1};
        ed = '{PERIOD[15:0], PERIOD[31:16], 16'h0007};
        cancel = 4'b1111;
        step();
        cancel = '0;
        req_valid = 4'b0001;
        req_delay[0*CNT_W +: CNT_W] = 16'd4;
        step();
        req_valid = '0;
        step();
        checks++;
        if (active[0] !== 1'b1) begin
            errors++; $display("FAIL mid_armed: active0=%b want 1", active[0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (cfg_done !== 1'b0 || req_ready !== '0 || tm_chipselect !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: cfg=%b rdy=%b cs=%b want 0", cfg_done, req_ready, tm_chipselect);
        end
        cfg_exp = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (active !== '0 || done !== '0) begin
            errors++; $display("FAIL mid_dropped: active=%b done=%b want 0000/0000", active, done);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tm_chipselect !== 1'b1 || tm_write_n !== 1'b0 || tm_address !== ea[k] ||
                tm_writedata !== ed[k] || req_ready !== '0) begin
                errors++; $display("FAIL mid_cfg%0d: cs=%b a=%0d d=%h rdy=%b want cs=1 a=%0d d=%h rdy=0",
                                   k, tm_chipselect, tm_address, tm_writedata, req_ready, ea[k], ed[k]);
            end
            step();
        end
        checks++;
        if (cfg_done !== 1'b1 || req_ready !== 4'b1111) begin
            errors++; $display("FAIL mid_ready: cfg=%b rdy=%b want 1/1111", cfg_done, req_ready);
        end
        for (int c = 0; c < 60; c++) begin
            checks++;
            if (done !== '0 || active !== '0) begin
                errors++; $display("FAIL mid_quiet: done=%b active=%b want 0000/0000", done, active);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_irq_service();
        test_same_expiry();
        test_cancel();
        test_zero_and_tick_arm();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
